uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Transmit scheduler that shares one UART transmitter between two byte sources: the CPU memory-mapped data register and a debug/monitor port.
- CPU bytes are buffered in an internal FIFO. Debug bytes use a single-entry valid/ready handshake.
- A round-robin arbiter picks the next byte. A small FSM sequences the transmitter's write/busy handshake.
- Sits between the IO register decode and the UART transmitter. It replaces the direct write-strobe connection.

Parameters:
- DEPTH, 16, CPU FIFO depth in bytes; must be a power of two, at least 2.
- AW, $clog2(DEPTH), FIFO pointer width; derived, do not override.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-low reset
- cpu_wr_i  in  1  CPU write strobe to the UART data register, one cycle per byte
- cpu_data_i  in  8  CPU byte
- cpu_clr_ovf_i  in  1  clears the sticky overflow flag
- cpu_full_o  out  1  FIFO full (count == DEPTH)
- cpu_level_o  out  AW+1  FIFO occupancy, 0..DEPTH
- cpu_ovf_o  out  1  sticky: a CPU byte was dropped
- dbg_valid_i  in  1  debug byte pending; held until accepted
- dbg_data_i  in  8  debug byte; stable while dbg_valid_i is high
- dbg_ready_o  out  1  one-cycle pulse: debug byte accepted
- uart_wr_o  out  1  one-cycle transmit strobe to the UART
- uart_data_o  out  8  byte to transmit; registered
- uart_busy_i  in  1  transmitter busy
- sched_busy_o  out  1  high when FSM is not IDLE or FIFO is non-empty

Behaviour:
- Reset (reset_i low, asynchronous):
  - FIFO pointers/count = 0, cpu_ovf_o = 0.
  - uart_wr_o = 0, uart_data_o = 8'h00, dbg_ready_o = 0.
  - FSM = IDLE, last_grant = DBG, so the CPU wins the first tie.
  - Reset mid-transfer: pending FIFO contents are discarded. A byte already strobed to the UART is not recalled.
- FIFO push:
  - Occurs on cpu_wr_i && !cpu_full_o.
  - If cpu_wr_i is high while full, the byte is dropped and cpu_ovf_o is set. This holds even if a pop occurs in the same cycle, because full is judged on the registered count.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop with count in 1..DEPTH-1 leaves count unchanged.
- cpu_ovf_o:
  - Cleared by cpu_clr_ovf_i.
  - If set and clear happen in the same cycle, set wins.
- Arbitration (evaluated in IDLE):
  - cpu_req = count != 0; dbg_req = dbg_valid_i.
  - Only one requesting: it is granted.
  - Both requesting: grant the source that is not last_grant.
  - last_grant updates on every grant.
- FSM states:
  - IDLE: if any request, go to ISSUE, latching the granted source and the byte into uart_data_o (FIFO head or dbg_data_i).
  - ISSUE (1 cycle): uart_wr_o = 1. Pop the FIFO if CPU granted; pulse dbg_ready_o if DBG granted. Go to GUARD.
  - GUARD (1 cycle): uart_busy_i is ignored, covering the transmitter's busy latency. Go to DRAIN.
  - DRAIN: stay while uart_busy_i = 1; go to IDLE when it is 0.
- Timing:
  - Request to strobe latency: 1 cycle from IDLE.
  - Minimum strobe-to-strobe spacing: 4 cycles (ISSUE, GUARD, DRAIN, IDLE).
- uart_data_o holds its value from ISSUE until the next grant.
- Debug port: dbg_ready_o is asserted only in ISSUE with DBG granted. Dropping dbg_valid_i before ready withdraws the request without error.
- cpu_level_o and cpu_full_o reflect the registered count. They update the cycle after a push or pop.

Test Plan:
- Reset, then CPU writes 8'h41 with uart_busy_i = 0:
  - uart_wr_o pulses 2 cycles after cpu_wr_i, with uart_data_o = 8'h41.
  - cpu_level_o goes 1 then 0; sched_busy_o returns low.
- CPU writes 8'h10..8'h1F (16 bytes) back-to-back while uart_busy_i is held high, then a 17th byte 8'h20:
  - cpu_full_o = 1 and cpu_ovf_o = 1; the 17th byte is dropped.
  - Releasing busy emits 8'h10..8'h1F in order.
  - cpu_clr_ovf_i then clears cpu_ovf_o.
- CPU FIFO holds 8'hA0,8'hA1 and dbg_valid_i = 1 with 8'hD0, all pending from reset:
  - Transmit order is A0, D0, A1.
  - dbg_ready_o pulses exactly once, in the ISSUE cycle for D0.
- Transmitter model asserting busy 1 cycle after uart_wr_o for 10 cycles:
  - No second uart_wr_o while busy; GUARD prevents a premature IDLE.
  - Strobe spacing = 1 + 1 + 10 + 1 cycles.
- Full FIFO, with cpu_wr_i in the same cycle as an ISSUE pop:
  - Byte dropped, ovf set; cpu_level_o = DEPTH-1 next cycle.
- Assert reset_i low during DRAIN with 5 bytes queued:
  - Outputs clear immediately (asynchronous), level = 0.
  - After release, no uart_wr_o occurs until a new request.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// ----------------------------------------------------------------------------
// uart_tx_sched_if
//   Bundles the three traffic groups handled by the UART transmit scheduler:
//     cpu_*  : write strobe/data from the IO register decode, overflow clear,
//              FIFO status (full, level, sticky overflow) back to the CPU
//     dbg_*  : single-entry valid/ready byte port from the debug monitor
//     uart_* : transmit strobe/data to the UART and its busy indication
//     sched_busy_o : scheduler activity (FSM not idle or bytes queued)
//   slave  : the scheduler side
//   master : the environment (CPU decode, debug monitor, UART transmitter)
// ----------------------------------------------------------------------------
interface uart_tx_sched_if #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
);
    logic          cpu_wr_i;
    logic [7:0]    cpu_data_i;
    logic          cpu_clr_ovf_i;
    logic          cpu_full_o;
    logic [AW:0]   cpu_level_o;
    logic          cpu_ovf_o;

    logic          dbg_valid_i;
    logic [7:0]    dbg_data_i;
    logic          dbg_ready_o;

    logic          uart_wr_o;
    logic [7:0]    uart_data_o;
    logic          uart_busy_i;

    logic          sched_busy_o;

    modport slave (
        input  cpu_wr_i, cpu_data_i, cpu_clr_ovf_i,
        output cpu_full_o, cpu_level_o, cpu_ovf_o,
        input  dbg_valid_i, dbg_data_i,
        output dbg_ready_o,
        output uart_wr_o, uart_data_o,
        input  uart_busy_i,
        output sched_busy_o
    );

    modport master (
        output cpu_wr_i, cpu_data_i, cpu_clr_ovf_i,
        input  cpu_full_o, cpu_level_o, cpu_ovf_o,
        output dbg_valid_i, dbg_data_i,
        input  dbg_ready_o,
        input  uart_wr_o, uart_data_o,
        output uart_busy_i,
        input  sched_busy_o
    );
endinterface

// File: rtl/uart_tx_sched.sv
// ----------------------------------------------------------------------------
// uart_tx_sched
//   Shares one UART transmitter between the CPU data register (buffered in a
//   DEPTH-byte FIFO) and a debug port (single-entry valid/ready). A
//   round-robin arbiter picks the next byte when the FSM is idle; the FSM then
//   strobes the UART for one cycle, waits one guard cycle for the
//   transmitter's busy flag to rise, and drains until busy drops.
//
//   Ports:
//     clk_i    : system clock
//     reset_i  : asynchronous, active-low reset
//     bus      : uart_tx_sched_if.slave (cpu_*, dbg_*, uart_*, sched_busy_o)
//
//   Parameters:
//     DEPTH : CPU FIFO depth, power of two, >= 2
//     AW    : pointer width, derived from DEPTH
// ----------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    uart_tx_sched_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, GUARD, DRAIN} state_t;
    typedef enum logic       {SRC_CPU, SRC_DBG}           src_t;

    // Granted source together with the byte latched for the UART.
    typedef struct packed {
        src_t       src;
        logic [7:0] data;
    } grant_t;

    // ------------------------------------------------------------------------
    // CPU FIFO
    // ------------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          push, pop;
    logic          ovf;

    state_t        state, state_nxt;
    grant_t        gnt, gnt_nxt;
    src_t          last_grant, last_grant_nxt;
    src_t          pick;
    logic          cpu_req, dbg_req;

    // Full is judged on the registered count, so a write that lands in the
    // same cycle as a pop from a full FIFO is still dropped.
    assign full = (count == (AW+1)'(DEPTH));
    assign push = bus.cpu_wr_i && !full;
    assign pop  = (state == ISSUE) && (gnt.src == SRC_CPU);

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= bus.cpu_data_i;
    end

    // ------------------------------------------------------------------------
    // Arbitration: on a tie the source that did not win last time is taken.
    // ------------------------------------------------------------------------
    assign cpu_req = (count != '0);
    assign dbg_req = bus.dbg_valid_i;
    assign pick    = (cpu_req && (!dbg_req || last_grant == SRC_DBG)) ? SRC_CPU : SRC_DBG;

    // ------------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        gnt_nxt        = gnt;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    gnt_nxt.src    = pick;
                    gnt_nxt.data   = (pick == SRC_CPU) ? mem[rd_ptr] : bus.dbg_data_i;
                    last_grant_nxt = pick;
                    state_nxt      = ISSUE;
                end
            end
            ISSUE:   state_nxt = GUARD;
            // Busy is not yet valid here: the transmitter raises it a cycle
            // after the strobe.
            GUARD:   state_nxt = DRAIN;
            DRAIN:   if (!bus.uart_busy_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State, FIFO pointers and overflow flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state      <= IDLE;
            gnt        <= '{src: SRC_CPU, data: 8'h00};
            last_grant <= SRC_DBG;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            last_grant <= last_grant_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (bus.cpu_wr_i && full)   ovf <= 1'b1;
            else if (bus.cpu_clr_ovf_i) ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.uart_wr_o    = (state == ISSUE);
    assign bus.uart_data_o  = gnt.data;
    assign bus.dbg_ready_o  = (state == ISSUE) && (gnt.src == SRC_DBG);
    assign bus.cpu_full_o   = full;
    assign bus.cpu_level_o  = count;
    assign bus.cpu_ovf_o    = ovf;
    assign bus.sched_busy_o = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;
    localparam int DEPTH = 16;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;
    always #5 clk_i = ~clk_i;

    uart_tx_sched_if #(.DEPTH(DEPTH)) sif ();
    uart_tx_sched #(.DEPTH(DEPTH)) dut (.clk_i(clk_i), .reset_i(reset_i), .bus(sif.slave));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (edge-indexed, queue based) -----------
    logic [7:0] mq[$];          // bytes accepted but not yet handed to the UART
    bit         m_idle;         // scheduler free to pick at the next edge
    bit         m_gcpu;         // last pick was the CPU
    bit         m_last_dbg;     // previous winner was debug
    int         m_dec;          // edge index of the last pick
    bit         m_ovf;
    bit         m_wr;           // strobe expected in the cycle after this edge
    logic [7:0] m_data;
    int         cyc = 0;

    // transmitter model / observation
    bit         auto_busy;
    int         busy_n;
    int         busy_left;
    logic [7:0] emitted[$];
    int         wr_cyc[$];
    int         ready_cnt;

    task automatic model_reset();
        mq.delete();
        m_idle = 1; m_gcpu = 0; m_last_dbg = 1; m_dec = 0;
        m_ovf = 0; m_wr = 0; m_data = 8'h00;
    endtask

    task automatic model_step();
        int cnt  = mq.size();
        bit full = (cnt == DEPTH);
        bit pop  = !m_idle && (cyc == m_dec + 1) && m_gcpu;
        m_wr = 0;
        if (sif.cpu_wr_i && full) m_ovf = 1;
        else if (sif.cpu_clr_ovf_i) m_ovf = 0;
        if (m_idle) begin
            bit creq = (cnt != 0);
            bit dreq = sif.dbg_valid_i;
            if (creq || dreq) begin
                m_gcpu     = creq && (!dreq || m_last_dbg);
                m_data     = m_gcpu ? mq[0] : sif.dbg_data_i;
                m_last_dbg = !m_gcpu;
                m_idle     = 0;
                m_dec      = cyc;
                m_wr       = 1;
            end
        end else if (cyc >= m_dec + 3 && !sif.uart_busy_i) begin
            m_idle = 1;
        end
        if (pop) void'(mq.pop_front());
        if (sif.cpu_wr_i && !full) mq.push_back(sif.cpu_data_i);
        cyc++;
    endtask

    task automatic compare();
        check("uart_wr",    sif.uart_wr_o,    m_wr);
        check("uart_data",  sif.uart_data_o,  m_data);
        check("dbg_ready",  sif.dbg_ready_o,  m_wr && !m_gcpu);
        check("level",      sif.cpu_level_o,  mq.size());
        check("full",       sif.cpu_full_o,   mq.size() == DEPTH);
        check("ovf",        sif.cpu_ovf_o,    m_ovf);
        check("sched_busy", sif.sched_busy_o, !m_idle || mq.size() != 0);
        if (auto_busy) check("wr_while_busy", sif.uart_wr_o && busy_left != 0, 0);
        if (sif.uart_wr_o === 1'b1) begin
            emitted.push_back(sif.uart_data_o);
            wr_cyc.push_back(cyc);
        end
        if (sif.dbg_ready_o === 1'b1) ready_cnt++;
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (reset_i) model_step();
        @(negedge clk_i);
        compare();
        if (auto_busy) begin
            sif.uart_busy_i = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            if (sif.uart_wr_o === 1'b1) busy_left = busy_n;
        end
        if (sif.dbg_ready_o === 1'b1) sif.dbg_valid_i = 1'b0;
    endtask

    task automatic cpu_push(input logic [7:0] b);
        sif.cpu_wr_i = 1'b1; sif.cpu_data_i = b;
        tick();
        sif.cpu_wr_i = 1'b0;
    endtask

    task automatic clear_obs();
        emitted.delete(); wr_cyc.delete(); ready_cnt = 0;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        model_reset();
        busy_left = 0; sif.uart_busy_i = 1'b0; sif.dbg_valid_i = 1'b0;
        sif.cpu_wr_i = 1'b0; sif.cpu_clr_ovf_i = 1'b0;
        tick(); tick();
        reset_i = 1'b1;
        clear_obs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark;
        int guard;
        sif.cpu_wr_i = 0; sif.cpu_data_i = 0; sif.cpu_clr_ovf_i = 0;
        sif.dbg_valid_i = 0; sif.dbg_data_i = 0; sif.uart_busy_i = 0;
        auto_busy = 1; busy_n = 0; busy_left = 0;
        model_reset();
        do_reset();

        // ---- single CPU byte, idle transmitter
        mark = cyc;
        cpu_push(8'h41);
        repeat (6) tick();
        check("t1_count",   emitted.size(), 1);
        check("t1_data",    (emitted.size() > 0) ? emitted[0] : 8'hxx, 8'h41);
        check("t1_latency", (wr_cyc.size() > 0) ? wr_cyc[0] - mark : -1, 2);
        check("t1_idle",    sif.sched_busy_o, 0);

        // ---- fill to full while transmitter stuck busy, overflow, drain
        do_reset();
        auto_busy = 0; sif.uart_busy_i = 1'b1;
        cpu_push(8'h0F);
        tick(); tick();
        for (int i = 0; i < 16; i++) cpu_push(8'h10 + 8'(i));
        cpu_push(8'h20);
        check("t2_full", sif.cpu_full_o, 1);
        check("t2_ovf",  sif.cpu_ovf_o, 1);
        sif.uart_busy_i = 1'b0; busy_left = 0; auto_busy = 1; busy_n = 2;
        guard = 0;
        while (emitted.size() < 17 && guard < 300) begin tick(); guard++; end
        check("t2_count", emitted.size(), 17);
        for (int i = 0; i < 16 && i + 1 < emitted.size(); i++)
            check("t2_order", emitted[i+1], 8'h10 + 8'(i));
        sif.cpu_clr_ovf_i = 1'b1; tick(); sif.cpu_clr_ovf_i = 1'b0;
        check("t2_ovf_clr", sif.cpu_ovf_o, 0);

        // ---- round robin: A0, D0, A1
        do_reset();
        busy_n = 1;
        cpu_push(8'hA0);
        sif.dbg_valid_i = 1'b1; sif.dbg_data_i = 8'hD0;
        cpu_push(8'hA1);
        repeat (30) tick();
        check("t3_count", emitted.size(), 3);
        check("t3_first",  (emitted.size() > 0) ? emitted[0] : 8'hxx, 8'hA0);
        check("t3_second", (emitted.size() > 1) ? emitted[1] : 8'hxx, 8'hD0);
        check("t3_third",  (emitted.size() > 2) ? emitted[2] : 8'hxx, 8'hA1);
        check("t3_ready_once", ready_cnt, 1);

        // ---- busy for 10 cycles after each strobe
        do_reset();
        busy_n = 10;
        cpu_push(8'h55);
        cpu_push(8'h66);
        repeat (40) tick();
        check("t4_count",   wr_cyc.size(), 2);
        check("t4_spacing", (wr_cyc.size() >= 2) ? wr_cyc[1] - wr_cyc[0] : -1, 13);

        // ---- write into a full FIFO during the ISSUE pop
        do_reset();
        auto_busy = 0; sif.uart_busy_i = 1'b1;
        cpu_push(8'h0F);
        tick(); tick();
        for (int i = 0; i < 16; i++) cpu_push(8'h30 + 8'(i));
        check("t5_full", sif.cpu_full_o, 1);
        clear_obs();
        sif.uart_busy_i = 1'b0;
        guard = 0;
        while (wr_cyc.size() == 0 && guard < 20) begin tick(); guard++; end
        check("t5_issue_seen", wr_cyc.size(), 1);
        sif.uart_busy_i = 1'b1;
        cpu_push(8'hEE);
        check("t5_level", sif.cpu_level_o, DEPTH - 1);
        check("t5_ovf",   sif.cpu_ovf_o, 1);

        // ---- asynchronous reset during DRAIN with 5 bytes queued
        do_reset();
        auto_busy = 0; sif.uart_busy_i = 1'b1;
        cpu_push(8'h0F);
        for (int i = 0; i < 5; i++) cpu_push(8'h70 + 8'(i));
        tick(); tick();
        check("t6_queued", sif.cpu_level_o, 5);
        #2 reset_i = 1'b0;
        #1 model_reset();
        compare();
        check("t6_rst_level", sif.cpu_level_o, 0);
        check("t6_rst_wr",    sif.uart_wr_o, 0);
        tick(); tick();
        reset_i = 1'b1; sif.uart_busy_i = 1'b0;
        clear_obs();
        repeat (10) tick();
        check("t6_no_wr", wr_cyc.size(), 0);

        // ---- randomized traffic
        do_reset();
        auto_busy = 1;
        for (int c = 0; c < 700; c++) begin
            int wr_pct = (c < 350) ? 35 : 75;
            busy_n = $urandom_range(0, 6);
            sif.cpu_wr_i      = ($urandom_range(0, 99) < wr_pct);
            sif.cpu_data_i    = 8'($urandom);
            sif.cpu_clr_ovf_i = ($urandom_range(0, 99) < 5);
            if (!sif.dbg_valid_i && $urandom_range(0, 99) < 15) begin
                sif.dbg_valid_i = 1'b1;
                sif.dbg_data_i  = 8'($urandom);
            end else if (sif.dbg_valid_i && sif.dbg_ready_o !== 1'b1 && $urandom_range(0, 99) < 3) begin
                sif.dbg_valid_i = 1'b0;
            end
            tick();
        end
        sif.cpu_wr_i = 0; sif.cpu_clr_ovf_i = 0; sif.dbg_valid_i = 0;
        repeat (200) tick();
        check("rand_drained", sif.sched_busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
